// File: rtl/risc_pkg.sv
// risc_pkg: types and constants shared by the RiSC core,
// its memory-side responder and the benches.
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MEM_DEPTH = 1 << AW;

  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] JLEZ  = 3'd4;
  localparam logic [2:0] JALR  = 3'd5;
  localparam logic [2:0] HALT  = 3'd7;

  localparam logic [1:0] LUI = 2'd2;
  localparam logic [1:0] LLI = 2'd3;

endpackage

// File: rtl/risc_mem_array.sv
// risc_mem_array: 2^AW x DW storage, one synchronous
// write port and one asynchronous read port.
module risc_mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_mem_responder.sv
// risc_mem_responder: memory responder for the RiSC core
// with a byte-stream program loader sharing the write port.
module risc_mem_responder #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_busy,
  output logic          ld_done
);

  import risc_pkg::*;

  localparam logic [2:0] WS_INIT =
    3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_state_t    state, state_n;
  logic [2:0]    wcnt, wcnt_n;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [AW-1:0] ld_ptr;
  logic          req_acc, ld_acc, go_resp;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign ld_ready  = (state == IDLE);
  assign req_ready = (state == IDLE) & ~ld_valid & ~ld_busy;
  assign ld_acc    = ld_valid & ld_ready;
  assign req_acc   = req_valid & req_ready;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    unique case (state)
      IDLE: begin
        if (req_acc) begin
          if (WAIT_STATES > 0) begin
            state_n = WAIT;
            wcnt_n  = WS_INIT;
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        if (wcnt == 3'd0) state_n = RESP;
        else wcnt_n = wcnt - 3'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign go_resp = (state_n == RESP);

  // zero-wait requests enter RESP on the acceptance edge,
  // before the latches have captured them
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign mem_we    = ~rst & (ld_acc | (go_resp & cur_we));
  assign mem_waddr = ld_acc ? ld_ptr  : cur_addr;
  assign mem_wdata = ld_acc ? ld_data : cur_wdata;

  risc_mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(cur_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= 3'd0;
      rsp_rdata <= '0;
      ld_ptr    <= '0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (req_acc) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (go_resp) rsp_rdata <= cur_we ? cur_wdata : rd_data;
      if (ld_acc) begin
        if (ld_last) begin
          ld_ptr  <= '0;
          ld_busy <= 1'b0;
          ld_done <= 1'b1;
        end else begin
          ld_ptr  <= ld_ptr + AW'(1);
          ld_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc_mem_responder.sv
// tb_risc_mem_responder: three responders (0, 1 and 7 wait
// states) on shared inputs, checked against a memory model.
module tb_risc_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       ld_valid, ld_last;
  logic [7:0] ld_data;

  logic       rdy [3];
  logic       rv  [3];
  logic [7:0] rd  [3];
  logic       ldr [3];
  logic       bsy [3];
  logic       dn  [3];

  int ws [3] = '{0, 1, 7};

  logic [7:0] mem_m [256];
  int         ptr_m;
  logic [7:0] ldbuf [300];

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] want;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  risc_mem_responder #(.WAIT_STATES(0)) d0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .ld_valid(ld_valid), .ld_ready(ldr[0]),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_busy(bsy[0]), .ld_done(dn[0])
  );

  risc_mem_responder #(.WAIT_STATES(1)) d1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .ld_valid(ld_valid), .ld_ready(ldr[1]),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_busy(bsy[1]), .ld_done(dn[1])
  );

  risc_mem_responder #(.WAIT_STATES(7)) d7 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy[2]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
    .ld_valid(ld_valid), .ld_ready(ldr[2]),
    .ld_data(ld_data), .ld_last(ld_last),
    .ld_busy(bsy[2]), .ld_done(dn[2])
  );

  task automatic chk(input string nm, input int act,
                     input int want);
    ntot++;
    if (act == want) npass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, want);
  endtask

  task automatic chk_reset(input int j, input string nm);
    chk({nm, "_req_ready"}, int'(rdy[j]), 1);
    chk({nm, "_ld_ready"}, int'(ldr[j]), 1);
    chk({nm, "_rsp_valid"}, int'(rv[j]), 0);
    chk({nm, "_rsp_rdata"}, int'(rd[j]), 0);
    chk({nm, "_ld_busy"}, int'(bsy[j]), 0);
    chk({nm, "_ld_done"}, int'(dn[j]), 0);
  endtask

  task automatic do_req(input logic we, input logic [7:0] a,
                        input logic [7:0] wd,
                        input logic [7:0] want,
                        input logic [7:0] want0,
                        input string nm);
    int first [3];
    int cnt   [3];
    logic [7:0] dat [3];
    logic [7:0] w;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!(rdy[0] & rdy[1] & rdy[2]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_wait"}, int'(n < 20), 1);
    if (n >= 20) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    for (int j = 0; j < 3; j++) begin
      first[j] = 0;
      cnt[j]   = 0;
      dat[j]   = 8'h00;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (rv[j]) begin
          cnt[j]++;
          if (first[j] == 0) begin
            first[j] = k;
            dat[j]   = rd[j];
          end
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      w = (j == 0) ? want0 : want;
      chk($sformatf("%s_lat_ws%0d", nm, ws[j]),
          first[j], ws[j] + 1);
      chk($sformatf("%s_pulse_ws%0d", nm, ws[j]),
          cnt[j], 1);
      chk($sformatf("%s_data_ws%0d", nm, ws[j]),
          int'(dat[j]), int'(w));
      chk($sformatf("%s_hold_ws%0d", nm, ws[j]),
          int'(rd[j]), int'(w));
    end
  endtask

  task automatic read_chk(input logic [7:0] a,
                          input string nm);
    do_req(1'b0, a, 8'h00, mem_m[a], mem_m[a], nm);
  endtask

  task automatic load(input int n, input string nm);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = ldbuf[i];
      ld_last  = (i == n - 1);
      if (i == 1) chk({nm, "_busy_mid"}, int'(bsy[1]), 1);
      t = 0;
      while (!(ldr[0] & ldr[1] & ldr[2]) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        chk({nm, "_ld_ready_wait"}, 0, 1);
        ld_valid = 1'b0;
        return;
      end
      @(posedge clk);
      mem_m[ptr_m[7:0]] = ldbuf[i];
      ptr_m = (i == n - 1) ? 0 : (ptr_m + 1) % 256;
      #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_done"}, int'(dn[1]), 1);
    chk({nm, "_busy_end"}, int'(bsy[1]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] old;
    int cnt;
    int len;
    logic       we;
    logic [7:0] a, wd, w;

    tbl[0] = '{1'b0, 8'h00, 8'h00, 8'hBF};
    tbl[1] = '{1'b0, 8'h26, 8'h00, 8'h70};
    tbl[2] = '{1'b1, 8'hFF, 8'h2A, 8'h2A};
    tbl[3] = '{1'b0, 8'hFF, 8'h00, 8'h2A};
    tbl[4] = '{1'b1, 8'hFE, 8'h06, 8'h06};
    tbl[5] = '{1'b0, 8'hFE, 8'h00, 8'h06};

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 8'h00;
    req_wdata = 8'h00;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = 8'h00;
    ptr_m = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++)
      chk_reset(j, $sformatf("rst_ws%0d", ws[j]));
    rst = 1'b0;

    for (int i = 0; i < 39; i++) ldbuf[i] = 8'(i * 5 + 1);
    ldbuf[0]  = 8'hBF;
    ldbuf[38] = 8'h70;
    load(39, "load39");

    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].want, tbl[i].want, $sformatf("tbl%0d", i));
      if (tbl[i].we) mem_m[tbl[i].addr] = tbl[i].wdata;
    end

    @(negedge clk);
    ld_valid  = 1'b1;
    ld_data   = 8'h3C;
    ld_last   = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    #1;
    chk("simul_req_ready", int'(rdy[1]), 0);
    chk("simul_ld_ready", int'(ldr[1]), 1);
    @(posedge clk);
    mem_m[ptr_m[7:0]] = 8'h3C;
    ptr_m = 0;
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    do_req(1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C, "simul_read");

    for (int i = 0; i < 257; i++) ldbuf[i] = 8'(i * 37 + 11);
    ldbuf[256] = 8'hC3;
    load(257, "wrap");
    do_req(1'b0, 8'h00, 8'h00, 8'hC3, 8'hC3, "wrap_addr0");
    read_chk(8'h01, "wrap_addr1");
    read_chk(8'hFF, "wrap_addrff");
    ldbuf[0] = 8'h99;
    load(1, "ptr0");
    do_req(1'b0, 8'h00, 8'h00, 8'h99, 8'h99, "ptr0_read");

    old = mem_m[8'h10];
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h10;
    req_wdata = 8'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_wait_ws1", int'(rv[1]), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(1, "midrst_ws1");
    chk_reset(2, "midrst_ws7");
    rst = 1'b0;
    ptr_m = 0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv[1] | rv[2]) cnt++;
    end
    chk("midrst_no_rsp", cnt, 0);
    do_req(1'b0, 8'h10, 8'h00, old, 8'h55, "midrst_read");
    do_req(1'b1, 8'h10, old, old, old, "midrst_resync");

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) ldbuf[i] = 8'($urandom);
        load(len, $sformatf("rnd_load%0d", it));
      end else begin
        we = 1'($urandom);
        a  = 8'($urandom);
        wd = 8'($urandom);
        w  = we ? wd : mem_m[a];
        do_req(we, a, wd, w, w, $sformatf("rnd%0d", it));
        if (we) mem_m[a] = wd;
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/risc_mem_responder.md
# risc_mem_responder

Memory-side responder for the 8-bit RiSC core: a 256×8 single-port memory that answers the core's fetch, LOAD and STORE requests over a valid/ready request channel and a single-cycle response pulse. A byte-stream loader port writes program images into memory from address 0x00. This replaces the core's direct array access, so the core becomes the initiator and this block the responder.

## Interface
- `AW`, 8, address width; memory depth is 2^AW.
- `DW`, 8, data width.
- `WAIT_STATES`, 1, extra cycles between request acceptance and response; legal range 0..7.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = STORE, 0 = fetch or LOAD.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  DW  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DW  read data; for a write, the data written.
- `ld_valid`  in  1  loader byte present.
- `ld_ready`  out  1  loader byte can be accepted.
- `ld_data`  in  DW  loader byte.
- `ld_last`  in  1  marks the final loader byte.
- `ld_busy`  out  1  a load session is in progress.
- `ld_done`  out  1  sticky; set after the `ld_last` byte is written.

## Operation
- FSM states and transitions:
  - IDLE: on a request handshake, go to WAIT if `WAIT_STATES` > 0, otherwise go to RESP.
  - WAIT: count down `WAIT_STATES` cycles, then go to RESP.
  - RESP: assert `rsp_valid`, then return to IDLE.
- Request handshake: accepted when `req_valid & req_ready`.
  - `req_ready = (state==IDLE) & ~ld_valid & ~ld_busy`.
  - `req_we`, `req_addr` and `req_wdata` are latched at acceptance. The core may change them afterwards.
  - At most one request is outstanding.
- Read: `rsp_rdata` = mem[latched addr], sampled on entry to RESP.
- Write: the memory commits on the edge entering RESP, and `rsp_rdata` = the written data. A read of the same address in a following request returns the new value.
- Loader handshake: `ld_ready = (state==IDLE)`.
  - Loader bytes take priority over the core. If `ld_valid` and `req_valid` are both high in IDLE, only the loader byte is accepted.
  - Each accepted byte is written to mem[ld_ptr], then `ld_ptr` increments.
  - `ld_ptr` starts at 0 and wraps from 0xFF to 0x00.
  - `ld_busy` is set on the first accepted byte and clears after the `ld_last` byte.
  - Accepting the `ld_last` byte sets `ld_done` and resets `ld_ptr` to 0. A new session can then begin; `ld_done` stays set.
- Memory contents are not cleared by reset.
- Address arithmetic is modulo 2^AW; no out-of-range error exists.

## Timing
- Reset values: `req_ready`=1, `ld_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `ld_busy`=0, `ld_done`=0, state=IDLE, `ld_ptr`=0, wait counter=0.
- Latency: `rsp_valid` rises `WAIT_STATES`+1 cycles after the acceptance edge.
  - With the default of 1, the response comes 2 cycles after acceptance.
  - With 0, it comes on the next edge.
- Throughput: `req_ready` returns high in the cycle after RESP, so one request completes every `WAIT_STATES`+2 cycles.
- Loader throughput: one byte per cycle while the FSM is in IDLE. Memory write latency is 1 edge.
- `rsp_valid` is high for exactly one cycle. `rsp_rdata` holds its value until the next response.
- Reset mid-operation: the FSM returns to IDLE, any uncommitted STORE in WAIT is dropped, no `rsp_valid` is issued, and `ld_ptr`, `ld_busy` and `ld_done` are cleared.

## Structure
- Shared package `risc_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, RESP};
  - constants `AW`, `DW` and the memory depth;
  - the core opcode constants (ADD=0, SUB=1, LOAD=2, STORE=3, JLEZ=4, JALR=5, HALT=7, LUI=2'd2, LLI=2'd3), so the core and the benches share them.
- Sub-module `risc_mem_array`: 2^AW×DW array with synchronous write and asynchronous read, single write port.
  - The loader and request paths are muxed onto the single write port in the top module.

## Test plan
- Load then fetch: load 39 bytes with `ld_last` on the final byte at address 0x26, then issue read requests to 0x00 and 0x26 → `ld_done`=1, `ld_busy`=0; the reads return 0xBF and 0x70.
- Latency sweep: with `WAIT_STATES` set to 0, 1 and 7, a read of 0xFE holding 0x06 returns `rsp_valid` at +1, +2 and +8 cycles, each a single-cycle pulse with `rsp_rdata`=0x06.
- Store then load: write 0x2A to 0xFF, then read 0xFF → the write response carries 0x2A and the read returns 0x2A.
- Simultaneous arrival: `ld_valid` and `req_valid` both high in IDLE → the loader byte is written to mem[`ld_ptr`] and `req_ready`=0. The request is accepted once `ld_valid` drops and `ld_busy` is clear.
- Loader wrap: load 257 bytes with `ld_last` on the last → byte 256 overwrites address 0x00; `ld_ptr` ends at 0.
- Reset mid-STORE: assert `rst` while in WAIT for a write of 0x55 to 0x10 → no `rsp_valid`; mem[0x10] is unchanged; all outputs are at their reset values the next cycle.
